// File: rtl/keypad_credential_entry_pkg.sv
// Shared types and key-code constants for the keypad credential entry block.
// Provides the entry FSM state type and the decimal-append helper.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENTRY  = 2'd1,
      SUBMIT = 2'd2
   } entry_state_e;

   localparam logic [3:0] KEY_CLEAR = 4'hC;
   localparam logic [3:0] KEY_ENTER = 4'hE;
   localparam logic [3:0] MAX_VALUE = 4'hF;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

   // Worst case 15*10+9 = 159, so 8 bits never wrap before saturation.
   function automatic logic [7:0] append_digit(input logic [3:0] value, input logic [3:0] digit);
      return ({4'd0, value} * 8'd10) + {4'd0, digit};
   endfunction

endpackage

// File: rtl/keypad_credential_entry_if.sv
// Keypad input and credential output bundle for keypad_credential_entry.
// The master side drives the raw keypad lines; the slave side is the design.
interface keypad_credential_entry_if;
   logic [3:0] ubKeyCode;
   logic       bKeyPressed;
   logic [3:0] ubCredential;
   logic       bCredValid;
   logic [3:0] ubEntryValue;
   logic [3:0] ubDigitCount;
   logic       bOverflow;

   modport master (
      output ubKeyCode, bKeyPressed,
      input  ubCredential, bCredValid, ubEntryValue, ubDigitCount, bOverflow
   );

   modport slave (
      input  ubKeyCode, bKeyPressed,
      output ubCredential, bCredValid, ubEntryValue, ubDigitCount, bOverflow
   );
endinterface

// File: rtl/keypad_credential_entry_debouncer.sv
// Two-flop synchronizer plus counter debouncer for the raw keypad lines.
// Emits a single-cycle key_event on each debounced press with the code captured then.
module key_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_code_raw,
   input  logic       key_pressed_raw,
   output logic       key_event,
   output logic [3:0] key_code
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             press_meta_q, press_sync_q;
   logic [3:0]       code_meta_q, code_sync_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             event_q, event_d;
   logic [3:0]       code_q, code_d;

   // Counter tracks consecutive samples disagreeing with the accepted level.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      event_d  = 1'b0;
      code_d   = code_q;
      if (press_sync_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = press_sync_q;
            event_d  = press_sync_q;
            if (press_sync_q) begin
               code_d = code_sync_q;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press_meta_q <= 1'b0;
         press_sync_q <= 1'b0;
         code_meta_q  <= 4'd0;
         code_sync_q  <= 4'd0;
         stable_q     <= 1'b0;
         cnt_q        <= '0;
         event_q      <= 1'b0;
         code_q       <= 4'd0;
      end else begin
         press_meta_q <= key_pressed_raw;
         press_sync_q <= press_meta_q;
         code_meta_q  <= key_code_raw;
         code_sync_q  <= code_meta_q;
         stable_q     <= stable_d;
         cnt_q        <= cnt_d;
         event_q      <= event_d;
         code_q       <= code_d;
      end
   end

   assign key_event = event_q;
   assign key_code  = code_q;

endmodule

// File: rtl/keypad_credential_entry.sv
// Keypad credential entry: accumulates decimal digits and submits them on enter.
// Define KEYPAD_TIMEOUT_EN to abandon an idle entry after TIMEOUT_CYCLES cycles.
module keypad_credential_entry
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 200
) (
   input logic                      clk,
   input logic                      rst,
   keypad_credential_entry_if.slave bus
);

   logic       key_event;
   logic [3:0] key_code;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .clk             (clk),
      .rst             (rst),
      .key_code_raw    (bus.ubKeyCode),
      .key_pressed_raw (bus.bKeyPressed),
      .key_event       (key_event),
      .key_code        (key_code)
   );

   entry_state_e state_q, state_d;
   logic [3:0]   value_q, value_d;
   logic [3:0]   count_q, count_d;
   logic         overflow_q, overflow_d;
   logic [3:0]   cred_q, cred_d;
   logic         valid_q, valid_d;
   logic [7:0]   product;
   logic         timeout_hit;

`ifdef KEYPAD_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;

   // Any key event, even an ignored code, counts as activity.
   assign timeout_hit = (state_q == ENTRY) && !key_event &&
                        (timeout_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      timeout_cnt_d = '0;
      if (state_q == ENTRY && !key_event && !timeout_hit) begin
         timeout_cnt_d = timeout_cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_cnt_q <= '0;
      end else begin
         timeout_cnt_q <= timeout_cnt_d;
      end
   end
`else
   // TIMEOUT_CYCLES only matters in the timeout build.
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT_CYCLES != 0);
   assign timeout_hit    = 1'b0;
`endif

   assign product = append_digit(value_q, key_code);

   always_comb begin
      state_d    = state_q;
      value_d    = value_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      cred_d     = cred_q;
      valid_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (key_event && is_digit(key_code)) begin
               state_d    = ENTRY;
               value_d    = key_code;
               count_d    = 4'd1;
               overflow_d = 1'b0;
            end
         end
         ENTRY: begin
            if (timeout_hit) begin
               state_d    = IDLE;
               value_d    = 4'd0;
               count_d    = 4'd0;
               overflow_d = 1'b0;
            end else if (key_event) begin
               if (is_digit(key_code)) begin
                  if (product > 8'd15) begin
                     value_d    = MAX_VALUE;
                     overflow_d = 1'b1;
                  end else begin
                     value_d = product[3:0];
                  end
                  if (count_q != 4'hF) begin
                     count_d = count_q + 4'd1;
                  end
               end else if (key_code == KEY_CLEAR) begin
                  state_d    = IDLE;
                  value_d    = 4'd0;
                  count_d    = 4'd0;
                  overflow_d = 1'b0;
               end else if (key_code == KEY_ENTER) begin
                  state_d = SUBMIT;
                  cred_d  = value_q;
                  valid_d = 1'b1;
               end
            end
         end
         SUBMIT: begin
            // Events landing here are dropped; the entry is wiped on exit.
            state_d    = IDLE;
            value_d    = 4'd0;
            count_d    = 4'd0;
            overflow_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         value_q    <= 4'd0;
         count_q    <= 4'd0;
         overflow_q <= 1'b0;
         cred_q     <= 4'd0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         value_q    <= value_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         cred_q     <= cred_d;
         valid_q    <= valid_d;
      end
   end

   assign bus.ubCredential = cred_q;
   assign bus.bCredValid   = valid_q;
   assign bus.ubEntryValue = value_q;
   assign bus.ubDigitCount = count_q;
   assign bus.bOverflow    = overflow_q;

endmodule

// File: tb/tb_keypad_credential_entry.sv
// Directed bench for keypad_credential_entry; submitted credentials are scoreboarded.
// Honours KEYPAD_TIMEOUT_EN for the idle-timeout scenario.
module tb_keypad_credential_entry;
   import keypad_pkg::*;

   localparam int unsigned DEB = 4;
   localparam int unsigned TO  = 20;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   pulses = 0;
   int   p0;
   int   lat;
   logic [3:0] exp_q[$];

   keypad_credential_entry_if bus();

   keypad_credential_entry #(
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Key spacing stays under 20 cycles so the timeout build never fires mid-sequence.
   task automatic applyStimulus(input logic [3:0] code, input int hold = 6);
      bus.ubKeyCode   = code;
      bus.bKeyPressed = 1'b1;
      repeat (hold) @(negedge clk);
      bus.bKeyPressed = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && bus.bCredValid === 1'b1) begin
         pulses++;
         checkOutput("pulse_pending", (exp_q.size() > 0) ? 8'd1 : 8'd0, 8'd1);
         if (exp_q.size() > 0) begin
            checkOutput("credential", {4'd0, bus.ubCredential}, {4'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst             = 1'b1;
      bus.ubKeyCode   = 4'd0;
      bus.bKeyPressed = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_cred",  {4'd0, bus.ubCredential}, 8'd0);
      checkOutput("rst_valid", {7'd0, bus.bCredValid},   8'd0);
      checkOutput("rst_value", {4'd0, bus.ubEntryValue}, 8'd0);
      checkOutput("rst_count", {4'd0, bus.ubDigitCount}, 8'd0);
      checkOutput("rst_ovf",   {7'd0, bus.bOverflow},    8'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Raw press to first visible output change.
      bus.ubKeyCode   = 4'd3;
      bus.bKeyPressed = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.ubDigitCount == 4'd1) begin
            lat = i;
            break;
         end
      end
      checkOutput("latency", 8'(lat), 8'(2 + DEB + 1));
      bus.bKeyPressed = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("first_digit", {4'd0, bus.ubEntryValue}, 8'd3);
      applyStimulus(KEY_CLEAR);
      checkOutput("clear_count", {4'd0, bus.ubDigitCount}, 8'd0);
      checkOutput("clear_value", {4'd0, bus.ubEntryValue}, 8'd0);

      p0 = pulses;
      applyStimulus(4'd2);
      exp_q.push_back(4'd2);
      applyStimulus(KEY_ENTER);
      checkOutput("submit2_pulses", 8'(pulses - p0), 8'd1);
      checkOutput("submit2_count",  {4'd0, bus.ubDigitCount}, 8'd0);
      checkOutput("submit2_cred",   {4'd0, bus.ubCredential}, 8'd2);

      applyStimulus(4'd1);
      checkOutput("v1", {4'd0, bus.ubEntryValue}, 8'd1);
      applyStimulus(4'd2);
      checkOutput("v12",       {4'd0, bus.ubEntryValue}, 8'd12);
      checkOutput("v12_count", {4'd0, bus.ubDigitCount}, 8'd2);
      exp_q.push_back(4'd12);
      applyStimulus(KEY_ENTER);
      checkOutput("cred12", {4'd0, bus.ubCredential}, 8'd12);

      applyStimulus(4'd1);
      applyStimulus(4'd9);
      checkOutput("v19_sat",   {4'd0, bus.ubEntryValue}, 8'd15);
      checkOutput("v19_ovf",   {7'd0, bus.bOverflow},    8'd1);
      checkOutput("v19_count", {4'd0, bus.ubDigitCount}, 8'd2);
      exp_q.push_back(4'd15);
      applyStimulus(KEY_ENTER);
      checkOutput("cred15",     {4'd0, bus.ubCredential}, 8'd15);
      checkOutput("ovf_clears", {7'd0, bus.bOverflow},    8'd0);

      applyStimulus(4'hB);
      checkOutput("ign_idle", {4'd0, bus.ubDigitCount}, 8'd0);
      applyStimulus(4'd4);
      applyStimulus(4'hA);
      applyStimulus(4'hD);
      applyStimulus(4'hF);
      checkOutput("ign_value", {4'd0, bus.ubEntryValue}, 8'd4);
      checkOutput("ign_count", {4'd0, bus.ubDigitCount}, 8'd1);
      exp_q.push_back(4'd4);
      applyStimulus(KEY_ENTER);
      checkOutput("cred4", {4'd0, bus.ubCredential}, 8'd4);

      p0 = pulses;
      applyStimulus(KEY_ENTER);
      applyStimulus(4'd3);
      checkOutput("v3", {4'd0, bus.ubEntryValue}, 8'd3);
      applyStimulus(KEY_CLEAR);
      applyStimulus(KEY_ENTER);
      checkOutput("noentry_pulses", 8'(pulses - p0), 8'd0);
      checkOutput("cred_retained",  {4'd0, bus.ubCredential}, 8'd4);

      // Short glitches must never pass the debouncer.
      for (int g = 0; g < 3; g++) begin
         bus.ubKeyCode   = 4'd5;
         bus.bKeyPressed = 1'b1;
         repeat (2) @(negedge clk);
         bus.bKeyPressed = 1'b0;
         repeat (3) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      checkOutput("glitch_count", {4'd0, bus.ubDigitCount}, 8'd0);
      applyStimulus(4'd5, 10);
      checkOutput("hold_value", {4'd0, bus.ubEntryValue}, 8'd5);
      checkOutput("hold_count", {4'd0, bus.ubDigitCount}, 8'd1);
      applyStimulus(KEY_CLEAR);

      for (int n = 0; n < 17; n++) begin
         applyStimulus(4'd0);
      end
      checkOutput("sat_count", {4'd0, bus.ubDigitCount}, 8'd15);
      checkOutput("sat_value", {4'd0, bus.ubEntryValue}, 8'd0);
      checkOutput("sat_ovf",   {7'd0, bus.bOverflow},    8'd0);
      applyStimulus(KEY_CLEAR);

      p0 = pulses;
      applyStimulus(4'd7);
      checkOutput("v7", {4'd0, bus.ubEntryValue}, 8'd7);
      repeat (25) @(negedge clk);
`ifdef KEYPAD_TIMEOUT_EN
      checkOutput("timeout_count", {4'd0, bus.ubDigitCount}, 8'd0);
      applyStimulus(KEY_ENTER);
      checkOutput("timeout_pulses", 8'(pulses - p0), 8'd0);
      checkOutput("timeout_value",  {4'd0, bus.ubEntryValue}, 8'd0);
      checkOutput("timeout_cred",   {4'd0, bus.ubCredential}, 8'd4);
`else
      checkOutput("hold_entry_count", {4'd0, bus.ubDigitCount}, 8'd1);
      exp_q.push_back(4'd7);
      applyStimulus(KEY_ENTER);
      checkOutput("late_pulses", 8'(pulses - p0), 8'd1);
      checkOutput("late_cred",   {4'd0, bus.ubCredential}, 8'd7);
`endif

      p0 = pulses;
      applyStimulus(4'd9);
      checkOutput("v9", {4'd0, bus.ubEntryValue}, 8'd9);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_cred",  {4'd0, bus.ubCredential}, 8'd0);
      checkOutput("async_valid", {7'd0, bus.bCredValid},   8'd0);
      checkOutput("async_value", {4'd0, bus.ubEntryValue}, 8'd0);
      checkOutput("async_count", {4'd0, bus.ubDigitCount}, 8'd0);
      checkOutput("async_ovf",   {7'd0, bus.bOverflow},    8'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("post_rst_pulses", 8'(pulses - p0), 8'd0);
      checkOutput("post_rst_count",  {4'd0, bus.ubDigitCount}, 8'd0);

      // A key held through reset has to re-qualify before it counts.
      bus.ubKeyCode   = 4'd5;
      bus.bKeyPressed = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("held_early", {4'd0, bus.ubDigitCount}, 8'd0);
      repeat (5) @(negedge clk);
      checkOutput("held_count", {4'd0, bus.ubDigitCount}, 8'd1);
      checkOutput("held_value", {4'd0, bus.ubEntryValue}, 8'd5);
      bus.bKeyPressed = 1'b0;
      repeat (8) @(negedge clk);
      applyStimulus(KEY_CLEAR);

      checkOutput("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
